// File: rtl/fpu_unpack_seq.sv
`default_nettype none
// ============================================================================
// Module      : fpu_unpack_seq
// Description : Sequential IEEE 754 single-precision operand unpacker.
//               Splits a 32-bit operand into sign, signed unbiased exponent
//               and a 24-bit significand with the hidden bit restored.
//               Subnormals are normalised one left shift per cycle, or
//               flushed to signed zero when FTZ=1. Produces the class flags
//               and the RISC-V FCLASS mask.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid / in_ready / ieee_in   operand handshake
//               out_valid / out_ready           result handshake
//               sign, exp_unb[9:0], significand[23:0], norm_shift[4:0]
//               is_zero, is_subnormal, is_inf, is_qnan, is_snan, fclass[9:0]
// Revision    : 1.0  initial release
// ============================================================================
module fpu_unpack_seq #(
  parameter int unsigned FTZ = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ieee_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [9:0]  exp_unb,
  output logic [23:0] significand,
  output logic [4:0]  norm_shift,
  output logic        is_zero,
  output logic        is_subnormal,
  output logic        is_inf,
  output logic        is_qnan,
  output logic        is_snan,
  output logic [9:0]  fclass
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // -126 in 10-bit two's complement: exponent of every subnormal before
  // normalisation.
  localparam logic [9:0] C_EXP_SUB = 10'h382;
  localparam logic [9:0] C_EXP_MAX = 10'd128;
  localparam logic [9:0] C_BIAS    = 10'd127;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  logic        r_sign;
  logic [9:0]  r_exp;
  logic [23:0] r_sig;
  logic [4:0]  r_shift;
  logic [4:0]  r_flags;   // {zero, subnormal, inf, qnan, snan}
  logic [9:0]  r_fclass;

  // ---------------------------------------------------------------- decode
  logic [7:0]  w_e;
  logic [22:0] w_m;
  logic        w_e_zero;
  logic        w_e_max;
  logic        w_m_zero;
  logic        w_sub;
  logic        w_ftz_en;
  logic        w_flush;
  logic        w_sub_norm;
  logic        w_zero;
  logic        w_inf;
  logic        w_nan;
  logic        w_qnan;
  logic        w_snan;
  logic        w_normal;
  logic        w_s;
  logic [9:0]  w_exp_cap;
  logic [23:0] w_sig_cap;
  logic [9:0]  w_fclass_cap;

  generate
    if (FTZ != 0) begin : g_ftz
      assign w_ftz_en = 1'b1;
    end else begin : g_no_ftz
      assign w_ftz_en = 1'b0;
    end
  endgenerate

  assign w_s        = ieee_in[31];
  assign w_e        = ieee_in[30:23];
  assign w_m        = ieee_in[22:0];
  assign w_e_zero   = (w_e == 8'd0);
  assign w_e_max    = (w_e == 8'hFF);
  assign w_m_zero   = (w_m == 23'd0);
  assign w_sub      = w_e_zero && !w_m_zero;
  // A flushed subnormal becomes indistinguishable from a true zero.
  assign w_flush    = w_sub && w_ftz_en;
  assign w_sub_norm = w_sub && !w_ftz_en;
  assign w_zero     = (w_e_zero && w_m_zero) || w_flush;
  assign w_inf      = w_e_max && w_m_zero;
  assign w_nan      = w_e_max && !w_m_zero;
  assign w_qnan     = w_nan && w_m[22];
  assign w_snan     = w_nan && !w_m[22];
  assign w_normal   = !w_e_zero && !w_e_max;

  always_comb begin
    w_exp_cap = {2'b00, w_e} - C_BIAS;
    w_sig_cap = {1'b1, w_m};
    if (w_zero) begin
      w_exp_cap = 10'd0;
      w_sig_cap = 24'd0;
    end else if (w_sub_norm) begin
      w_exp_cap = C_EXP_SUB;
      w_sig_cap = {1'b0, w_m};
    end else if (w_e_max) begin
      // Inf and NaN share {1,M}; for Inf M is zero, giving 0x800000.
      w_exp_cap = C_EXP_MAX;
    end
  end

  always_comb begin
    w_fclass_cap    = 10'd0;
    w_fclass_cap[0] =  w_s && w_inf;
    w_fclass_cap[1] =  w_s && w_normal;
    w_fclass_cap[2] =  w_s && w_sub_norm;
    w_fclass_cap[3] =  w_s && w_zero;
    w_fclass_cap[4] = !w_s && w_zero;
    w_fclass_cap[5] = !w_s && w_sub_norm;
    w_fclass_cap[6] = !w_s && w_normal;
    w_fclass_cap[7] = !w_s && w_inf;
    w_fclass_cap[8] =  w_snan;
    w_fclass_cap[9] =  w_qnan;
  end

  // ----------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = w_sub_norm ? S_NORM : S_HOLD;
        end
      end
      S_NORM: begin
        // Pre-shift bit 22 set means this shift brings the MSB to bit 23.
        if (r_sig[22]) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------ FSM outputs
  always_comb begin
    in_ready  = rst_n && (r_state == S_IDLE);
    out_valid = (r_state == S_HOLD);
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_exp    <= 10'd0;
      r_sig    <= 24'd0;
      r_shift  <= 5'd0;
      r_flags  <= 5'd0;
      r_fclass <= 10'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign   <= w_s;
            r_exp    <= w_exp_cap;
            r_sig    <= w_sig_cap;
            r_shift  <= 5'd0;
            r_flags  <= {w_zero, w_sub_norm, w_inf, w_qnan, w_snan};
            r_fclass <= w_fclass_cap;
          end
        end
        S_NORM: begin
          r_sig   <= {r_sig[22:0], 1'b0};
          r_exp   <= r_exp - 10'd1;
          r_shift <= r_shift + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign sign         = r_sign;
  assign exp_unb      = r_exp;
  assign significand  = r_sig;
  assign norm_shift   = r_shift;
  assign is_zero      = r_flags[4];
  assign is_subnormal = r_flags[3];
  assign is_inf       = r_flags[2];
  assign is_qnan      = r_flags[1];
  assign is_snan      = r_flags[0];
  assign fclass       = r_fclass;

endmodule
`default_nettype wire

// File: tb/tb_fpu_unpack_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_unpack_seq
// Description : Self-checking bench for fpu_unpack_seq. Instance 0 has FTZ=0,
//               instance 1 has FTZ=1. Expected results come from a
//               behavioural model and flow through a scoreboard queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_unpack_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, sign;
  logic [1:0]  is_zero, is_sub, is_inf, is_qnan, is_snan;
  logic [31:0] ieee_in [2];
  logic [9:0]  exp_unb [2];
  logic [23:0] sig     [2];
  logic [4:0]  nsh     [2];
  logic [9:0]  fcl     [2];

  fpu_unpack_seq #(.FTZ(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .ieee_in(ieee_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sign(sign[0]), .exp_unb(exp_unb[0]), .significand(sig[0]),
    .norm_shift(nsh[0]), .is_zero(is_zero[0]), .is_subnormal(is_sub[0]),
    .is_inf(is_inf[0]), .is_qnan(is_qnan[0]), .is_snan(is_snan[0]),
    .fclass(fcl[0])
  );

  fpu_unpack_seq #(.FTZ(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .ieee_in(ieee_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sign(sign[1]), .exp_unb(exp_unb[1]), .significand(sig[1]),
    .norm_shift(nsh[1]), .is_zero(is_zero[1]), .is_subnormal(is_sub[1]),
    .is_inf(is_inf[1]), .is_qnan(is_qnan[1]), .is_snan(is_snan[1]),
    .fclass(fcl[1])
  );

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] sig;
    logic [4:0]  sh;
    logic [4:0]  flags;   // {zero, subnormal, inf, qnan, snan}
    logic [9:0]  fclass;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [31:0] v, input bit ftz);
    exp_t        e;
    logic [7:0]  ef;
    logic [22:0] mf;
    int          msb;
    int          k;
    ef = v[30:23];
    mf = v[22:0];
    e.sign = v[31]; e.exp = '0; e.sig = '0; e.sh = '0;
    e.flags = '0; e.fclass = '0; e.lat = 1;
    if (ef == 8'd0 && (mf == 23'd0 || ftz)) begin
      e.flags[4] = 1'b1;
      e.fclass[v[31] ? 3 : 4] = 1'b1;
    end else if (ef == 8'd0) begin
      msb = 0;
      for (int i = 0; i < 23; i++) if (mf[i]) msb = i;
      k = 23 - msb;
      e.sig = {1'b0, mf} << k;
      e.exp = 10'(-126 - k);
      e.sh = 5'(k);
      e.flags[3] = 1'b1;
      e.fclass[v[31] ? 2 : 5] = 1'b1;
      e.lat = k + 1;
    end else if (ef == 8'hFF && mf == 23'd0) begin
      e.exp = 10'd128; e.sig = 24'h800000; e.flags[2] = 1'b1;
      e.fclass[v[31] ? 0 : 7] = 1'b1;
    end else if (ef == 8'hFF) begin
      e.exp = 10'd128; e.sig = {1'b1, mf};
      if (mf[22]) begin e.flags[1] = 1'b1; e.fclass[9] = 1'b1; end
      else        begin e.flags[0] = 1'b1; e.fclass[8] = 1'b1; end
    end else begin
      e.exp = 10'(int'(ef) - 127);
      e.sig = {1'b1, mf};
      e.fclass[v[31] ? 1 : 6] = 1'b1;
    end
    return e;
  endfunction

  task automatic compare_out(input int inst, input exp_t e, input string pfx);
    check_val({pfx, "_valid"},  out_valid[inst], 64'd1);
    check_val({pfx, "_ready"},  in_ready[inst], 64'd0);
    check_val({pfx, "_sign"},   sign[inst], e.sign);
    check_val({pfx, "_exp"},    exp_unb[inst], e.exp);
    check_val({pfx, "_sig"},    sig[inst], e.sig);
    check_val({pfx, "_shift"},  nsh[inst], e.sh);
    check_val({pfx, "_flags"},  {is_zero[inst], is_sub[inst], is_inf[inst],
                                 is_qnan[inst], is_snan[inst]}, e.flags);
    check_val({pfx, "_fclass"}, fcl[inst], e.fclass);
  endtask

  task automatic check_cleared(input int inst, input string pfx);
    check_val({pfx, "_valid"},  out_valid[inst], 64'd0);
    check_val({pfx, "_data"},   {sign[inst], exp_unb[inst], sig[inst], nsh[inst]}, 64'd0);
    check_val({pfx, "_flags"},  {is_zero[inst], is_sub[inst], is_inf[inst],
                                 is_qnan[inst], is_snan[inst], fcl[inst]}, 64'd0);
  endtask

  // One full transaction: accept, measure latency, optionally stall, release.
  task automatic run_op(input int inst, input logic [31:0] v, input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    while (!in_ready[inst] && lat < 50) begin @(posedge clk); #1; lat++; end
    check_val("ready_before", in_ready[inst], 64'd1);
    ieee_in[inst] = v;
    in_valid[inst] = 1'b1;
    sb_q.push_back(model(v, inst == 1));
    @(posedge clk); #1;
    in_valid[inst] = 1'b0;
    ieee_in[inst] = $urandom;
    lat = 1;
    while (!out_valid[inst] && lat < 60) begin @(posedge clk); #1; lat++; end
    e = sb_q.pop_front();
    check_val("latency", lat, e.lat);
    compare_out(inst, e, "out");
    repeat (hold) begin @(posedge clk); #1; compare_out(inst, e, "hold"); end
    out_ready[inst] = 1'b1;
    @(posedge clk); #1;
    out_ready[inst] = 1'b0;
    check_val("done_valid", out_valid[inst], 64'd0);
    check_val("done_ready", in_ready[inst], 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] vecs [12];
    vecs = '{32'h3F800000, 32'h00000001, 32'h807FFFFF, 32'hFF800000,
             32'h7FA00000, 32'h7FC00000, 32'h80000000, 32'h7F7FFFFF,
             32'h00800000, 32'h00400000, 32'h80012345, 32'h7F800000};

    rst_n = 1'b0;
    in_valid = '0; out_ready = '0;
    ieee_in[0] = '0; ieee_in[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_cleared(i, "reset");
      check_val("reset_ready_low", in_ready[i], 64'd0);
    end
    rst_n = 1'b1;
    #1;
    check_val("ready_after_reset", in_ready[0], 64'd1);

    // Main patterns on the FTZ=0 instance
    foreach (vecs[i]) run_op(0, vecs[i], 0);
    for (int i = 0; i < 4; i++) run_op(0, $urandom, 1);

    // Backpressure with a pending operand waiting at the input
    ieee_in[0] = 32'h3F800000;
    in_valid[0] = 1'b1;
    sb_q.push_back(model(32'h3F800000, 1'b0));
    @(posedge clk); #1;
    ieee_in[0] = 32'h40000000;
    sb_q.push_back(model(32'h40000000, 1'b0));
    e = sb_q.pop_front();
    compare_out(0, e, "bp_first");
    repeat (5) begin @(posedge clk); #1; compare_out(0, e, "bp_hold"); end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check_val("bp_release_valid", out_valid[0], 64'd0);
    check_val("bp_release_ready", in_ready[0], 64'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    e = sb_q.pop_front();
    compare_out(0, e, "bp_next");
    check_val("bp_next_exp1", exp_unb[0], 64'd1);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check_val("bp_done_valid", out_valid[0], 64'd0);

    // Reset while normalising: the in-flight operand must vanish
    ieee_in[0] = 32'h00000001;
    in_valid[0] = 1'b1;
    sb_q.push_back(model(32'h00000001, 1'b0));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_norm_busy", in_ready[0], 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_cleared(0, "norm_reset");
    check_val("norm_reset_ready", in_ready[0], 64'd0);
    sb_q.delete();
    rst_n = 1'b1;
    #1;
    check_val("norm_release_ready", in_ready[0], 64'd1);
    repeat (30) @(posedge clk);
    #1;
    check_cleared(0, "no_stale");

    // Flush-to-zero instance
    run_op(1, 32'h00000001, 0);
    run_op(1, 32'h807FFFFF, 0);
    run_op(1, 32'h3F800000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
